// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter.
// Holds request flag codes, FSM states and a small decode helper.
package mem_arbiter_pkg;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  // 11 is illegal and behaves like idle, so only 01/10 start work
  function automatic logic rw_valid(input logic [1:0] f);
    return (f == RW_READ) || (f == RW_WRITE);
  endfunction

endpackage

// File: rtl/mem_arbiter_slot.sv
// Per-port request latch plus the port's done/read_data registers.
// One instance per cache refill port; the shared engine drives complete.
module mem_arbiter_slot
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    rw_flag,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic [MW-1:0] wmask,
  input  logic          complete,
  input  logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          req_we,
  output logic [AW-1:0] req_addr,
  output logic [DW-1:0] req_wdata,
  output logic [MW-1:0] req_wmask,
  output logic [DW-1:0] read_data
);

  logic          valid_q, valid_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [MW-1:0] wmask_q, wmask_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          accept;

  // accept only while free; complete only while valid, so never both
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    accept  = !valid_q && rw_valid(rw_flag);
    if (accept) begin
      valid_d = 1'b1;
      we_d    = (rw_flag == RW_WRITE);
      addr_d  = addr;
      wdata_d = wdata;
      wmask_d = wmask;
    end
    if (complete) begin
      valid_d = 1'b0;
      done_d  = 1'b1;
      if (!we_q) begin
        rdata_d = rdata;
      end
    end
  end

  // slot registers; reset drops any request in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  assign busy      = valid_q;
  assign done      = done_q;
  assign req_we    = we_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign req_wmask = wmask_q;
  assign read_data = rdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter onto one req/ack memory bus.
// Port 0 is the data side, port 1 the instruction side.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MASK_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [3:0]              rw_flag,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] write_data,
  input  logic [2*MASK_WIDTH-1:0] write_mask,
  output logic [2*DATA_WIDTH-1:0] read_data,
  output logic [1:0]              busy,
  output logic [1:0]              done,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [MASK_WIDTH-1:0]   mem_wmask,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ack
);

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   rr_q, rr_d;
  logic   ack_hit;
  logic [1:0] complete;

  logic                  slot_we    [2];
  logic [ADDR_WIDTH-1:0] slot_addr  [2];
  logic [DATA_WIDTH-1:0] slot_wdata [2];
  logic [MASK_WIDTH-1:0] slot_wmask [2];

  for (genvar p = 0; p < 2; p++) begin : g_slot
    mem_arbiter_slot #(
      .AW (ADDR_WIDTH),
      .DW (DATA_WIDTH),
      .MW (MASK_WIDTH)
    ) u_slot (
      .clk       (CLK),
      .rst       (RST),
      .rw_flag   (rw_flag[2*p +: 2]),
      .addr      (addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .wdata     (write_data[p*DATA_WIDTH +: DATA_WIDTH]),
      .wmask     (write_mask[p*MASK_WIDTH +: MASK_WIDTH]),
      .complete  (complete[p]),
      .rdata     (mem_rdata),
      .busy      (busy[p]),
      .done      (done[p]),
      .req_we    (slot_we[p]),
      .req_addr  (slot_addr[p]),
      .req_wdata (slot_wdata[p]),
      .req_wmask (slot_wmask[p]),
      .read_data (read_data[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // ack only counts while a request is actually on the bus
  assign ack_hit  = (state_q == S_ISSUE) && mem_ack;
  assign complete = {ack_hit & grant_q, ack_hit & ~grant_q};

  // engine state, granted port and round-robin pointer
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // grant in IDLE, wait for ack in ISSUE, one response cycle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      S_IDLE: begin
        if (|busy) begin
          state_d = S_ISSUE;
          grant_d = (&busy) ? rr_q : busy[1];
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          state_d = S_RESP;
          rr_d    = ~grant_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // bus fields come straight from the granted slot, stable while held
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (state_q == S_ISSUE) begin
      mem_req   = 1'b1;
      mem_we    = slot_we[grant_q];
      mem_addr  = slot_addr[grant_q];
      mem_wdata = slot_wdata[grant_q];
      mem_wmask = slot_wmask[grant_q];
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference.
// Memory side is a programmable-latency responder.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  rw_flag = '0;
  logic [63:0] addr = '0;
  logic [63:0] write_data = '0;
  logic [7:0]  write_mask = '0;
  logic [63:0] read_data;
  logic [1:0]  busy;
  logic [1:0]  done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  mem_arbiter dut (
    .CLK        (CLK),
    .RST        (RST),
    .rw_flag    (rw_flag),
    .addr       (addr),
    .write_data (write_data),
    .write_mask (write_mask),
    .read_data  (read_data),
    .busy       (busy),
    .done       (done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (32'h5A5A0000 ^ a);
  endfunction

  // memory responder: ack after ack_delay cycles of mem_req
  bit auto_ack = 1'b1;
  bit force_ack = 1'b0;
  int ack_delay = 0;
  int wait_cnt = 0;

  always @(posedge CLK) begin
    #2;
    mem_ack = 1'b0;
    if (force_ack) begin
      mem_ack = 1'b1;
    end else if (auto_ack && mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_for(mem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // reference: each port owns at most one transaction; one transaction
  // is on the bus at a time, followed by a response cycle and a grant
  // cycle before the next one; contention resolves by the rr pointer
  logic [1:0]  m_pend = '0;
  logic [1:0]  m_we = '0;
  logic [31:0] m_addr [2];
  logic [31:0] m_wd [2];
  logic [3:0]  m_wm [2];
  logic [31:0] m_rd [2];
  int          m_bus = -1;
  int          m_resp = -1;
  int          m_rr = 0;
  int          nb;
  int          nr;
  logic [1:0]  np;
  logic [1:0]  fl;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0;
      m_wd[i] = '0;
      m_wm[i] = '0;
      m_rd[i] = '0;
    end
  end

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_pend = '0;
      m_we = '0;
      m_bus = -1;
      m_resp = -1;
      m_rr = 0;
      for (int i = 0; i < 2; i++) m_rd[i] = '0;
    end else begin
      nb = m_bus;
      nr = -1;
      np = m_pend;
      if (m_bus >= 0 && mem_ack) begin
        nr = m_bus;
        if (!m_we[m_bus]) m_rd[m_bus] = mem_rdata;
        np[m_bus] = 1'b0;
        m_rr = 1 - m_bus;
        nb = -1;
      end else if (m_bus < 0 && m_resp < 0 && m_pend != 2'b00) begin
        if (m_pend == 2'b11) nb = m_rr;
        else nb = m_pend[1] ? 1 : 0;
      end
      for (int p = 0; p < 2; p++) begin
        fl = rw_flag[2*p +: 2];
        if (!m_pend[p] && (fl == 2'b01 || fl == 2'b10)) begin
          np[p] = 1'b1;
          m_we[p] = (fl == 2'b10);
          m_addr[p] = addr[32*p +: 32];
          m_wd[p] = write_data[32*p +: 32];
          m_wm[p] = write_mask[4*p +: 4];
        end
      end
      m_pend = np;
      m_bus = nb;
      m_resp = nr;
    end
  end

  // every-cycle comparison against the reference
  always @(negedge CLK) begin
    chk("busy", {62'd0, busy}, {62'd0, m_pend});
    chk("done", {62'd0, done},
        {62'd0, (m_resp == 1), (m_resp == 0)});
    chk("read_data", read_data, {m_rd[1], m_rd[0]});
    chk("mem_req", {63'd0, mem_req}, {63'd0, (m_bus >= 0)});
    if (m_bus >= 0) begin
      chk("mem_we", {63'd0, mem_we}, {63'd0, m_we[m_bus]});
      chk("mem_addr", {32'd0, mem_addr}, {32'd0, m_addr[m_bus]});
      chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, m_wd[m_bus]});
      chk("mem_wmask", {60'd0, mem_wmask}, {60'd0, m_wm[m_bus]});
    end else begin
      chk("mem_idle_fields",
          {mem_we, mem_addr, mem_wdata[26:0], mem_wmask}, 64'd0);
    end
  end

  // log of accepted bus transactions
  logic [31:0] served [$];
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wmask = '0;

  always @(negedge CLK) begin
    if (!RST && mem_req && mem_ack) begin
      served.push_back(mem_addr);
      last_wdata = mem_wdata;
      last_wmask = mem_wmask;
    end
  end

  task automatic set_req(input int p, input logic [1:0] f,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m);
    rw_flag[2*p +: 2] = f;
    addr[32*p +: 32] = a;
    write_data[32*p +: 32] = d;
    write_mask[4*p +: 4] = m;
  endtask

  task automatic clr_req(input int p);
    rw_flag[2*p +: 2] = 2'b00;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_done(input int p, input int budget);
    int k;
    k = 0;
    while (!done[p] && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk("done_within_budget", {63'd0, done[p]}, 64'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int cnt;
  int k;

  initial begin
    // reset then idle
    cyc(3);
    #1 RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("idle_mem_req", {63'd0, mem_req}, 64'd0);
    end
    chk("idle_busy", {62'd0, busy}, 64'd0);
    chk("idle_done", {62'd0, done}, 64'd0);
    chk("idle_read_data", read_data, 64'd0);

    // single read on port 1, ack in first mem_req cycle
    ack_delay = 0;
    set_req(1, 2'b01, 32'h100, 32'h0, 4'h0);
    cyc(1);
    clr_req(1);
    chk("rd1_busy_t1", {62'd0, busy}, 64'd2);
    chk("rd1_req_t1", {63'd0, mem_req}, 64'd0);
    cyc(1);
    chk("rd1_busy_t2", {62'd0, busy}, 64'd2);
    chk("rd1_req_t2", {63'd0, mem_req}, 64'd1);
    chk("rd1_addr_t2", {32'd0, mem_addr}, 64'h100);
    cyc(1);
    chk("rd1_done_t3", {62'd0, done}, 64'd2);
    chk("rd1_busy_t3", {62'd0, busy}, 64'd0);
    chk("rd1_data_t3", {32'd0, read_data[63:32]}, 64'hDEADBEEF);
    cyc(1);
    chk("rd1_done_t4", {62'd0, done}, 64'd0);
    chk("rd1_data_held", {32'd0, read_data[63:32]}, 64'hDEADBEEF);

    // port 0 write with four wait states
    ack_delay = 4;
    set_req(0, 2'b10, 32'h40, 32'h12345678, 4'b0011);
    cyc(1);
    clr_req(0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (done[0]) cnt++;
    end
    chk("wr0_done_pulses", 64'(cnt), 64'd1);
    chk("wr0_read_data_kept", {32'd0, read_data[31:0]}, 64'd0);
    chk("wr0_bus_wdata", {32'd0, last_wdata}, 64'h12345678);
    chk("wr0_bus_wmask", {60'd0, last_wmask}, 64'h3);

    // illegal rw_flag is never accepted
    set_req(0, 2'b11, 32'h44, 32'h0, 4'h0);
    cyc(1);
    chk("illegal_busy", {62'd0, busy}, 64'd0);
    clr_req(0);
    cyc(2);
    chk("illegal_no_req", {63'd0, mem_req}, 64'd0);

    // write with empty mask still completes
    ack_delay = 1;
    set_req(1, 2'b10, 32'h80, 32'hCAFEF00D, 4'h0);
    cyc(1);
    clr_req(1);
    wait_done(1, 20);
    chk("mask0_wmask", {60'd0, last_wmask}, 64'd0);
    chk("mask0_wdata", {32'd0, last_wdata}, 64'hCAFEF00D);
    chk("mask0_rd_kept", {32'd0, read_data[63:32]}, 64'hDEADBEEF);

    // back-to-back on port 0, new request during done cycle
    cyc(2);
    set_req(0, 2'b01, 32'h40, 32'h0, 4'h0);
    cyc(1);
    wait_done(0, 20);
    set_req(0, 2'b01, 32'h44, 32'h0, 4'h0);
    cyc(1);
    clr_req(0);
    chk("b2b_busy", {63'd0, busy[0]}, 64'd1);
    chk("b2b_gap", {63'd0, mem_req}, 64'd0);
    cyc(1);
    chk("b2b_req", {63'd0, mem_req}, 64'd1);
    chk("b2b_addr", {32'd0, mem_addr}, 64'h44);
    wait_done(0, 20);
    chk("b2b_data", {32'd0, read_data[31:0]}, 64'h5A5A0044);

    // simultaneous requests after reset, held to show alternation
    do_reset();
    served.delete();
    ack_delay = 0;
    set_req(0, 2'b01, 32'h200, 32'h0, 4'h0);
    set_req(1, 2'b01, 32'h300, 32'h0, 4'h0);
    cyc(1);
    chk("sim_both_busy", {62'd0, busy}, 64'd3);
    cyc(23);
    clr_req(0);
    clr_req(1);
    k = 0;
    while ((busy != 2'b00 || mem_req) && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("sim_drained", {62'd0, busy}, 64'd0);
    chk("sim_served_count", {63'd0, (served.size() >= 6)}, 64'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < served.size())
        chk("sim_order", {32'd0, served[i]},
            (i % 2 == 1) ? 64'h300 : 64'h200);
    end

    // reset while a request is on the bus
    auto_ack = 1'b0;
    cyc(2);
    set_req(1, 2'b01, 32'h500, 32'h0, 4'h0);
    cyc(1);
    clr_req(1);
    k = 0;
    while (!mem_req && k < 10) begin
      @(negedge CLK);
      k++;
    end
    chk("rst_mid_req_seen", {63'd0, mem_req}, 64'd1);
    #1 RST = 1'b1;
    #1;
    chk("rst_mid_req_drop", {63'd0, mem_req}, 64'd0);
    chk("rst_mid_busy_drop", {62'd0, busy}, 64'd0);
    @(negedge CLK);
    #1 RST = 1'b0;
    force_ack = 1'b1;
    @(negedge CLK);
    force_ack = 1'b0;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (done != 2'b00) cnt++;
    end
    chk("rst_late_ack_no_done", 64'(cnt), 64'd0);
    auto_ack = 1'b1;
    ack_delay = 0;
    set_req(1, 2'b01, 32'h600, 32'h0, 4'h0);
    cyc(1);
    clr_req(1);
    wait_done(1, 20);
    chk("rst_recover_data", {32'd0, read_data[63:32]}, 64'h5A5A0600);
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
